// File: rtl/fix_pkg.sv
// rtl/fix_pkg.sv - shared FIX field constants, state/error enums and field record type
package fix_pkg;

    localparam logic [7:0] FIX_SOH     = 8'h01;
    localparam logic [7:0] FIX_EQ      = 8'h3d;
    localparam logic [7:0] FIX_DIGIT_0 = 8'h30;
    localparam logic [7:0] FIX_DIGIT_9 = 8'h39;

    localparam int FIX_MAX_VAL_LEN = 32;
    localparam int FIX_TAG_DIGITS  = 5;
    localparam int FIX_TAG_W       = 17;
    localparam int FIX_LEN_W       = 6;

    typedef enum logic [1:0] {
        ST_TAG     = 2'd0,
        ST_VALUE   = 2'd1,
        ST_DISCARD = 2'd2
    } fsm_state_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_NON_DIGIT = 2'd1,
        ERR_TAG_LEN   = 2'd2,
        ERR_OVERFLOW  = 2'd3
    } err_code_e;

    typedef struct packed {
        logic [FIX_TAG_W-1:0]         tag;
        logic [8*FIX_MAX_VAL_LEN-1:0] val;
        logic [FIX_LEN_W-1:0]         len;
        logic                         trunc;
    } fld_rec_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= FIX_DIGIT_0) && (b <= FIX_DIGIT_9);
    endfunction

endpackage

// File: rtl/fix_value_buf.sv
// rtl/fix_value_buf.sv - byte-indexed value store with length counter and truncation flag
module fix_value_buf #(
    parameter int MAX_VAL_LEN = 32,
    parameter int LEN_W       = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     wr_i,
    input  logic [7:0]               data_i,
    output logic [8*MAX_VAL_LEN-1:0] val_o,
    output logic [LEN_W-1:0]         len_o,
    output logic                     trunc_o
);

    logic [8*MAX_VAL_LEN-1:0] val_q, val_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic                     trunc_q, trunc_d;

    always_comb begin
        val_d   = val_q;
        len_d   = len_q;
        trunc_d = trunc_q;
        if (clear_i) begin
            val_d   = '0;
            len_d   = '0;
            trunc_d = 1'b0;
        end else if (wr_i) begin
            // Bytes beyond capacity are dropped; only the flag records they existed.
            if (len_q == LEN_W'(MAX_VAL_LEN)) begin
                trunc_d = 1'b1;
            end else begin
                val_d[{len_q, 3'b000} +: 8] = data_i;
                len_d = len_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q   <= '0;
            len_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            val_q   <= val_d;
            len_q   <= len_d;
            trunc_q <= trunc_d;
        end
    end

    assign val_o   = val_q;
    assign len_o   = len_q;
    assign trunc_o = trunc_q;

endmodule

// File: rtl/fix_field_assembler.sv
// rtl/fix_field_assembler.sv - builds tag/value field records from FIX parser strobes
module fix_field_assembler
    import fix_pkg::*;
#(
    parameter int MAX_VAL_LEN = 32,
    parameter int TAG_DIGITS  = 5,
    parameter int TAG_W       = 17,
    parameter int LEN_W       = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               data_i,
    input  logic                     tag_s_i,
    input  logic                     tag_e_i,
    input  logic                     value_s_i,
    input  logic                     value_e_i,
    output logic                     fld_valid_o,
    input  logic                     fld_ready_i,
    output logic [TAG_W-1:0]         fld_tag_o,
    output logic [8*MAX_VAL_LEN-1:0] fld_val_o,
    output logic [LEN_W-1:0]         fld_len_o,
    output logic                     fld_trunc_o,
    output logic                     err_o,
    output logic [1:0]               err_code_o
);

    localparam int DIG_W = $clog2(TAG_DIGITS + 1);

    fsm_state_e               state_q, state_d;
    err_code_e                code_q, code_d;
    logic [TAG_W-1:0]         tag_acc_q, tag_acc_d;
    logic [DIG_W-1:0]         digits_q, digits_d;
    logic                     fld_valid_q, fld_valid_d;
    logic [TAG_W-1:0]         fld_tag_q, fld_tag_d;
    logic [8*MAX_VAL_LEN-1:0] fld_val_q, fld_val_d;
    logic [LEN_W-1:0]         fld_len_q, fld_len_d;
    logic                     fld_trunc_q, fld_trunc_d;
    logic                     err_q, err_d;
    err_code_e                err_code_q, err_code_d;

    logic                     ts, te, vs, ve;
    logic                     buf_clear, buf_wr, done;
    logic [TAG_W+3:0]         mac;
    logic [8*MAX_VAL_LEN-1:0] buf_val;
    logic [LEN_W-1:0]         buf_len;
    logic                     buf_trunc;

    // Strobe priority: value_e > tag_e > value_s > tag_s.
    assign ve = value_e_i;
    assign te = tag_e_i & ~value_e_i;
    assign vs = value_s_i & ~tag_e_i & ~value_e_i;
    assign ts = tag_s_i & ~value_s_i & ~tag_e_i & ~value_e_i;

    assign mac = (TAG_W+4)'(tag_acc_q) * (TAG_W+4)'(10) + (TAG_W+4)'(data_i - FIX_DIGIT_0);

    fix_value_buf #(
        .MAX_VAL_LEN(MAX_VAL_LEN),
        .LEN_W      (LEN_W)
    ) u_value_buf (
        .clk    (clk),
        .rst    (rst),
        .clear_i(buf_clear),
        .wr_i   (buf_wr),
        .data_i (data_i),
        .val_o  (buf_val),
        .len_o  (buf_len),
        .trunc_o(buf_trunc)
    );

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        tag_acc_d   = tag_acc_q;
        digits_d    = digits_q;
        fld_valid_d = fld_valid_q;
        fld_tag_d   = fld_tag_q;
        fld_val_d   = fld_val_q;
        fld_len_d   = fld_len_q;
        fld_trunc_d = fld_trunc_q;
        err_d       = 1'b0;
        err_code_d  = ERR_NONE;
        buf_clear   = 1'b0;
        buf_wr      = 1'b0;
        done        = 1'b0;

        case (state_q)
            ST_TAG: begin
                if (ts) begin
                    if (!is_digit(data_i)) begin
                        code_d  = ERR_NON_DIGIT;
                        state_d = ST_DISCARD;
                    end else if (digits_q == DIG_W'(TAG_DIGITS)) begin
                        code_d  = ERR_TAG_LEN;
                        state_d = ST_DISCARD;
                    end else begin
                        tag_acc_d = TAG_W'(mac);
                        digits_d  = digits_q + DIG_W'(1);
                    end
                end else if (te) begin
                    if (digits_q == '0) begin
                        code_d  = ERR_TAG_LEN;
                        state_d = ST_DISCARD;
                    end else begin
                        buf_clear = 1'b1;
                        state_d   = ST_VALUE;
                    end
                end
            end
            ST_VALUE: begin
                if (ve) begin
                    done      = 1'b1;
                    tag_acc_d = '0;
                    digits_d  = '0;
                    state_d   = ST_TAG;
                end else if (vs) begin
                    buf_wr = 1'b1;
                end
            end
            ST_DISCARD: begin
                if (ve) begin
                    err_d      = 1'b1;
                    err_code_d = code_q;
                    tag_acc_d  = '0;
                    digits_d   = '0;
                    state_d    = ST_TAG;
                end
            end
            default: state_d = ST_TAG;
        endcase

        // One-entry output register: a completion while a record is stuck is dropped.
        if (done) begin
            if (!fld_valid_q || fld_ready_i) begin
                fld_valid_d = 1'b1;
                fld_tag_d   = tag_acc_q;
                fld_val_d   = buf_val;
                fld_len_d   = buf_len;
                fld_trunc_d = buf_trunc;
            end else begin
                err_d      = 1'b1;
                err_code_d = ERR_OVERFLOW;
            end
        end else if (fld_valid_q && fld_ready_i) begin
            fld_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_TAG;
            code_q      <= ERR_NONE;
            tag_acc_q   <= '0;
            digits_q    <= '0;
            fld_valid_q <= 1'b0;
            fld_tag_q   <= '0;
            fld_val_q   <= '0;
            fld_len_q   <= '0;
            fld_trunc_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            tag_acc_q   <= tag_acc_d;
            digits_q    <= digits_d;
            fld_valid_q <= fld_valid_d;
            fld_tag_q   <= fld_tag_d;
            fld_val_q   <= fld_val_d;
            fld_len_q   <= fld_len_d;
            fld_trunc_q <= fld_trunc_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign fld_valid_o = fld_valid_q;
    assign fld_tag_o   = fld_tag_q;
    assign fld_val_o   = fld_val_q;
    assign fld_len_o   = fld_len_q;
    assign fld_trunc_o = fld_trunc_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_fix_field_assembler.sv
// tb/tb_fix_field_assembler.sv - scoreboard bench for fix_field_assembler
module tb_fix_field_assembler;
    import fix_pkg::*;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic [7:0]                     data_i = '0;
    logic                           tag_s_i = 1'b0;
    logic                           tag_e_i = 1'b0;
    logic                           value_s_i = 1'b0;
    logic                           value_e_i = 1'b0;
    logic                           fld_ready_i = 1'b1;
    logic                           fld_valid_o;
    logic [FIX_TAG_W-1:0]           fld_tag_o;
    logic [8*FIX_MAX_VAL_LEN-1:0]   fld_val_o;
    logic [FIX_LEN_W-1:0]           fld_len_o;
    logic                           fld_trunc_o;
    logic                           err_o;
    logic [1:0]                     err_code_o;

    fld_rec_t   exp_rec_q[$];
    logic [1:0] exp_err_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    fix_field_assembler dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .tag_s_i    (tag_s_i),
        .tag_e_i    (tag_e_i),
        .value_s_i  (value_s_i),
        .value_e_i  (value_e_i),
        .fld_valid_o(fld_valid_o),
        .fld_ready_i(fld_ready_i),
        .fld_tag_o  (fld_tag_o),
        .fld_val_o  (fld_val_o),
        .fld_len_o  (fld_len_o),
        .fld_trunc_o(fld_trunc_o),
        .err_o      (err_o),
        .err_code_o (err_code_o)
    );

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic fld_rec_t mk(input int tag, input string v);
        fld_rec_t r;
        r = '0;
        r.tag = FIX_TAG_W'(tag);
        for (int i = 0; i < v.len() && i < FIX_MAX_VAL_LEN; i++) r.val[8*i +: 8] = v[i];
        r.len   = FIX_LEN_W'((v.len() > FIX_MAX_VAL_LEN) ? FIX_MAX_VAL_LEN : v.len());
        r.trunc = (v.len() > FIX_MAX_VAL_LEN);
        return r;
    endfunction

    always @(negedge clk) begin
        fld_rec_t   e;
        logic [1:0] ec;
        if (mon_en) begin
            if (fld_valid_o && fld_ready_i) begin
                if (exp_rec_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_record: got tag %0d expected no record", fld_tag_o);
                end else begin
                    e = exp_rec_q.pop_front();
                    chk("rec_tag", 256'(fld_tag_o), 256'(e.tag));
                    chk("rec_val", fld_val_o, e.val);
                    chk("rec_len", 256'(fld_len_o), 256'(e.len));
                    chk("rec_trunc", 256'(fld_trunc_o), 256'(e.trunc));
                end
            end
            if (err_o) begin
                if (exp_err_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_err: got code %0d expected no error", err_code_o);
                end else begin
                    ec = exp_err_q.pop_front();
                    chk("err_code", 256'(err_code_o), 256'(ec));
                end
            end
        end
    end

    task automatic cyc(input logic ts, input logic te, input logic vs, input logic ve, input logic [7:0] d);
        @(posedge clk);
        #1;
        tag_s_i   = ts;
        tag_e_i   = te;
        value_s_i = vs;
        value_e_i = ve;
        data_i    = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_body(input string tag, input string val);
        for (int i = 0; i < tag.len(); i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, tag[i]);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, FIX_EQ);
        for (int i = 0; i < val.len(); i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, val[i]);
    endtask

    task automatic send_field(input string tag, input string val);
        send_body(tag, val);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, FIX_SOH);
    endtask

    task automatic chk_all_zero(input string tagname);
        chk({tagname, "_valid"}, 256'(fld_valid_o), 256'(0));
        chk({tagname, "_tag"}, 256'(fld_tag_o), 256'(0));
        chk({tagname, "_val"}, fld_val_o, 256'(0));
        chk({tagname, "_len"}, 256'(fld_len_o), 256'(0));
        chk({tagname, "_trunc"}, 256'(fld_trunc_o), 256'(0));
        chk({tagname, "_err"}, 256'(err_o), 256'(0));
        chk({tagname, "_err_code"}, 256'(err_code_o), 256'(0));
    endtask

    initial begin
        string long_val;
        int    wait_cyc;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // Basic field "35=D"
        exp_rec_q.push_back(mk(35, "D"));
        send_field("35", "D");
        idle(2);

        // Non-digit tag, then a normal field recovers
        exp_err_q.push_back(2'd1);
        send_field("3A", "X");
        exp_rec_q.push_back(mk(8, "FIX"));
        send_field("8", "FIX");
        idle(2);

        // Six-digit tag and empty tag
        exp_err_q.push_back(2'd2);
        send_field("123456", "1");
        exp_err_q.push_back(2'd2);
        send_field("", "5");
        idle(2);

        // 40-byte value truncated to 32
        long_val = "";
        for (int i = 0; i < 40; i++) long_val = $sformatf("%s%c", long_val, 8'(8'h41 + i % 26));
        exp_rec_q.push_back(mk(58, long_val));
        send_field("58", long_val);

        // Empty value and a five-digit tag at the digit limit
        exp_rec_q.push_back(mk(10, ""));
        send_field("10", "");
        exp_rec_q.push_back(mk(99999, "Q"));
        send_field("99999", "Q");
        idle(3);

        // Backpressure: first record held, second dropped, third loads on acceptance
        fld_ready_i = 1'b0;
        exp_rec_q.push_back(mk(11, "AA"));
        send_field("11", "AA");
        exp_err_q.push_back(2'd3);
        send_field("12", "BB");
        idle(3);
        exp_rec_q.push_back(mk(13, "CC"));
        send_body("13", "CC");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, FIX_SOH);
        fld_ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_stays_on_load_accept", 256'(fld_valid_o), 256'(1));
        chk("third_tag_loaded", 256'(fld_tag_o), 256'(13));
        tag_s_i = 1'b0; tag_e_i = 1'b0; value_s_i = 1'b0; value_e_i = 1'b0;
        idle(3);

        // Reset mid-value abandons the field
        send_body("49", "AB");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h43);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("mid_reset");
        rst = 1'b0;
        tag_s_i = 1'b0; tag_e_i = 1'b0; value_s_i = 1'b0; value_e_i = 1'b0;
        exp_rec_q.push_back(mk(56, "Z"));
        send_field("56", "Z");
        idle(1);

        wait_cyc = 0;
        while ((exp_rec_q.size() != 0 || exp_err_q.size() != 0) && wait_cyc < 50) begin
            @(posedge clk);
            wait_cyc++;
        end
        idle(2);
        chk("pending_records", 256'(exp_rec_q.size()), 256'(0));
        chk("pending_errors", 256'(exp_err_q.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
